// File: rtl/gpu_timing_pkg.sv
// Raster timing constants and shared types for the VGA timing generator.
// One clk is two VGA pixels, so horizontal values are in clocks (640 px -> 320 clk).
package gpu_timing_pkg;

  // Horizontal timing, in clocks
  localparam int unsigned H_VISIBLE  = 320;
  localparam int unsigned H_FRONT    = 8;
  localparam int unsigned H_SYNC     = 48;
  localparam int unsigned H_BACK     = 24;
  localparam int unsigned H_BORDER   = 32;

  // Vertical timing, in lines
  localparam int unsigned V_VISIBLE  = 480;
  localparam int unsigned V_FRONT    = 10;
  localparam int unsigned V_SYNC     = 2;
  localparam int unsigned V_BACK     = 33;

  // Extra sync pipeline depth to line up with the downstream pixel stages
  localparam int unsigned SYNC_DELAY = 1;

  // Game-space window
  localparam int unsigned GAME_W     = 256;
  localparam int unsigned GAME_H     = 240;

  typedef logic [8:0] hcount_t;
  typedef logic [9:0] vcount_t;
  typedef logic [7:0] game_coord_t;

  // Coordinate value used outside the game window; never matches an object
  localparam game_coord_t OFFSCREEN = 8'hFF;

endpackage

// File: rtl/sync_delay_m.sv
// Reset-to-ones shift register that delays the active-low sync pair.
// DEPTH = 0 is a plain wire-through.
module sync_delay_m #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift the sync pair one stage per clock; idle (high) after reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= {WIDTH{1'b1}};
        end
      end else begin
        stage_r[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign q = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_m.sv
// 640x480@60 VGA raster timing at half pixel rate plus 256x240 game-space coordinates,
// VRAM write window and frame-start pulse. All outputs are registered (1 clk latency);
// hsync/vsync get SYNC_DELAY further clocks through sync_delay_m.
// Optional feature macro: GPU_VBLANK_IRQ_EN adds the latched vblank_irq / irq_ack pair.
module video_timing_m #(
  parameter int unsigned H_VISIBLE  = gpu_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT    = gpu_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC     = gpu_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK     = gpu_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE  = gpu_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT    = gpu_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC     = gpu_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK     = gpu_timing_pkg::V_BACK,
  parameter int unsigned H_BORDER   = gpu_timing_pkg::H_BORDER,
  parameter int unsigned SYNC_DELAY = gpu_timing_pkg::SYNC_DELAY
) (
  input  logic       clk,
  input  logic       rst,
`ifdef GPU_VBLANK_IRQ_EN
  input  logic       irq_ack,
  output logic       vblank_irq,
`endif
  output logic [7:0] current_x,
  output logic [7:0] current_y,
  output logic       in_game,
  output logic       writable,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync
);

  import gpu_timing_pkg::*;

  localparam hcount_t H_LAST    = hcount_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam vcount_t V_LAST    = vcount_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam hcount_t H_GAME_LO = hcount_t'(H_BORDER);
  localparam hcount_t H_GAME_HI = hcount_t'(H_BORDER + GAME_W);
  localparam hcount_t H_SYNC_LO = hcount_t'(H_VISIBLE + H_FRONT);
  localparam hcount_t H_SYNC_HI = hcount_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam vcount_t V_VIS     = vcount_t'(V_VISIBLE);
  localparam vcount_t V_SYNC_LO = vcount_t'(V_VISIBLE + V_FRONT);
  localparam vcount_t V_SYNC_HI = vcount_t'(V_VISIBLE + V_FRONT + V_SYNC);

  hcount_t     hcount_r;
  vcount_t     vcount_r;

  game_coord_t current_x_s;
  game_coord_t current_y_s;
  logic        in_game_s;
  logic        writable_s;
  logic        frame_start_s;
  logic        hsync_s;
  logic        vsync_s;
  logic        hsync_r;
  logic        vsync_r;

  // Raster counters: hcount every clock, vcount on each line wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_r <= 9'd0;
      vcount_r <= 10'd0;
    end else if (hcount_r == H_LAST) begin
      hcount_r <= 9'd0;
      if (vcount_r == V_LAST) begin
        vcount_r <= 10'd0;
      end else begin
        vcount_r <= vcount_r + 10'd1;
      end
    end else begin
      hcount_r <= hcount_r + 9'd1;
    end
  end

  // Decode the current raster position into next-cycle output values
  always_comb begin
    in_game_s     = 1'b0;
    current_x_s   = OFFSCREEN;
    current_y_s   = OFFSCREEN;
    writable_s    = 1'b0;
    frame_start_s = 1'b0;
    hsync_s       = 1'b1;
    vsync_s       = 1'b1;

    if ((hcount_r >= H_GAME_LO) && (hcount_r < H_GAME_HI) && (vcount_r < V_VIS)) begin
      in_game_s   = 1'b1;
      current_x_s = game_coord_t'(hcount_r - H_GAME_LO);
    end else begin
      in_game_s   = 1'b0;
      current_x_s = OFFSCREEN;
    end

    // Two VGA lines per game line
    if (vcount_r < V_VIS) begin
      current_y_s = vcount_r[8:1];
      writable_s  = 1'b0;
    end else begin
      current_y_s = OFFSCREEN;
      writable_s  = 1'b1;
    end

    if ((hcount_r == 9'd0) && (vcount_r == V_VIS)) begin
      frame_start_s = 1'b1;
    end else begin
      frame_start_s = 1'b0;
    end

    if ((hcount_r >= H_SYNC_LO) && (hcount_r < H_SYNC_HI)) begin
      hsync_s = 1'b0;
    end else begin
      hsync_s = 1'b1;
    end

    if ((vcount_r >= V_SYNC_LO) && (vcount_r < V_SYNC_HI)) begin
      vsync_s = 1'b0;
    end else begin
      vsync_s = 1'b1;
    end
  end

  // Register all decoded outputs; sync pair idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      current_x   <= OFFSCREEN;
      current_y   <= OFFSCREEN;
      in_game     <= 1'b0;
      writable    <= 1'b0;
      frame_start <= 1'b0;
      hsync_r     <= 1'b1;
      vsync_r     <= 1'b1;
    end else begin
      current_x   <= current_x_s;
      current_y   <= current_y_s;
      in_game     <= in_game_s;
      writable    <= writable_s;
      frame_start <= frame_start_s;
      hsync_r     <= hsync_s;
      vsync_r     <= vsync_s;
    end
  end

  sync_delay_m #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (2)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .d   ({hsync_r, vsync_r}),
    .q   ({hsync, vsync})
  );

`ifdef GPU_VBLANK_IRQ_EN
  // Vblank interrupt latch: sets with frame_start, cleared by ack, set wins a tie
  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_irq <= 1'b0;
    end else if (frame_start_s) begin
      vblank_irq <= 1'b1;
    end else if (irq_ack) begin
      vblank_irq <= 1'b0;
    end else begin
      vblank_irq <= vblank_irq;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_m.sv
// Self-checking bench for video_timing_m. Instance A uses the full 640x480 timing
// (SYNC_DELAY=1); instance B shrinks the vertical timing (16/2/2/3 lines, SYNC_DELAY=3)
// so whole frames, vblank and vsync fit in a short run. A raster model derived from
// elapsed clocks since reset release predicts every output on every cycle.
`timescale 1ns/1ps
module tb_video_timing_m;

  localparam int HT   = 400;
  localparam int HB   = 32;
  localparam int HS0  = 328;
  localparam int HSW  = 48;

  localparam int VV_A = 480, VF_A = 10, VS_A = 2, VB_A = 33, D_A = 1;
  localparam int VV_B = 16,  VF_B = 2,  VS_B = 2, VB_B = 3,  D_B = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       ig;
    logic       wr;
    logic       fs;
    logic       hs;
    logic       vs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_ack = 1'b0;

  logic [7:0] a_x, a_y, b_x, b_y;
  logic a_ig, a_wr, a_fs, a_hs, a_vs;
  logic b_ig, b_wr, b_fs, b_hs, b_vs;
`ifdef GPU_VBLANK_IRQ_EN
  logic a_irq, b_irq;
  logic exp_irq_a = 1'b0;
  logic exp_irq_b = 1'b0;
`endif

  int k = 0;           // posedges since reset release
  int pass_cnt = 0;
  int total_cnt = 0;
  int phase = 1;
  bit seen_edge = 1'b0;
  logic ack_s = 1'b0;
  int hs_run = 0, vs_run = 0, last_fs = -1;

  always #5 clk = ~clk;

  video_timing_m #(.SYNC_DELAY(D_A)) dut_a (
    .clk(clk), .rst(rst),
`ifdef GPU_VBLANK_IRQ_EN
    .irq_ack(irq_ack), .vblank_irq(a_irq),
`endif
    .current_x(a_x), .current_y(a_y), .in_game(a_ig), .writable(a_wr),
    .frame_start(a_fs), .hsync(a_hs), .vsync(a_vs)
  );

  video_timing_m #(.V_VISIBLE(VV_B), .V_FRONT(VF_B), .V_SYNC(VS_B), .V_BACK(VB_B),
                   .SYNC_DELAY(D_B)) dut_b (
    .clk(clk), .rst(rst),
`ifdef GPU_VBLANK_IRQ_EN
    .irq_ack(irq_ack), .vblank_irq(b_irq),
`endif
    .current_x(b_x), .current_y(b_y), .in_game(b_ig), .writable(b_wr),
    .frame_start(b_fs), .hsync(b_hs), .vsync(b_vs)
  );

  // Expected outputs after kk clocks out of reset (kk = 0 means reset state)
  function automatic obs_t model(int kk, int vv, int vf, int vsw, int vb, int d);
    obs_t o;
    int p, h, v, q, vt;
    o.x = 8'hFF; o.y = 8'hFF; o.ig = 1'b0; o.wr = 1'b0; o.fs = 1'b0;
    o.hs = 1'b1; o.vs = 1'b1;
    if (kk == 0) return o;
    vt = vv + vf + vsw + vb;
    p = kk - 1;
    h = p % HT;
    v = (p / HT) % vt;
    o.ig = (h >= HB) && (h < HB + 256) && (v < vv);
    if (o.ig) o.x = 8'(h - HB);
    if (v < vv) o.y = 8'(v / 2);
    o.wr = (v >= vv);
    o.fs = (h == 0) && (v == vv);
    q = p - d;
    if (q >= 0) begin
      h = q % HT;
      v = (q / HT) % vt;
      o.hs = !((h >= HS0) && (h < HS0 + HSW));
      o.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else if (total_cnt - pass_cnt <= 40) begin
      $display("FAIL %s k=%0d phase=%0d got=%0h expected=%0h", name, k, phase, got, exp);
    end
  endtask

  // Elapsed-clock counter and ack sampling, mirroring what the DUT sees at each edge
  always @(posedge clk) begin
    seen_edge <= 1'b1;
    ack_s     <= irq_ack;
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    obs_t ea, eb, ga, gb;
    if (seen_edge) begin
      ea = model(k, VV_A, VF_A, VS_A, VB_A, D_A);
      eb = model(k, VV_B, VF_B, VS_B, VB_B, D_B);
      ga = {a_x, a_y, a_ig, a_wr, a_fs, a_hs, a_vs};
      gb = {b_x, b_y, b_ig, b_wr, b_fs, b_hs, b_vs};
      check("raster_a", 64'(ga), 64'(ea));
      check("raster_b", 64'(gb), 64'(eb));

`ifdef GPU_VBLANK_IRQ_EN
      if (k == 0) begin
        exp_irq_a = 1'b0; exp_irq_b = 1'b0;
      end else begin
        if (ea.fs) exp_irq_a = 1'b1; else if (ack_s) exp_irq_a = 1'b0;
        if (eb.fs) exp_irq_b = 1'b1; else if (ack_s) exp_irq_b = 1'b0;
      end
      check("irq_a", 64'(a_irq), 64'(exp_irq_a));
      check("irq_b", 64'(b_irq), 64'(exp_irq_b));
      if (phase == 1 && k == 6410) check("irq_before_ack", 64'(b_irq), 64'd1);
      if (phase == 1 && k == 6411) check("irq_after_ack", 64'(b_irq), 64'd0);
      if (phase == 2 && k == 6401) check("irq_set_wins", 64'(b_irq), 64'd1);
`endif

      // Hand-computed anchors
      if (k == 0)    check("rst_hsync", 64'({a_hs, a_vs, b_hs, b_vs}), 64'hF);
      if (k == 1)    check("x_after_release", 64'(a_x), 64'hFF);
      if (k == 33)   check("x_first", 64'({a_ig, a_x}), 64'h100);
      if (k == 288)  check("x_last", 64'({a_ig, a_x}), 64'h1FF);
      if (k == 289)  check("x_past_window", 64'({a_ig, a_x}), 64'h0FF);
      if (k == 329)  check("hsync_before", 64'(a_hs), 64'd1);
      if (k == 330)  check("hsync_start_d1", 64'(a_hs), 64'd0);
      if (k == 331)  check("hsync_b_before", 64'(b_hs), 64'd1);
      if (k == 332)  check("hsync_start_d3", 64'(b_hs), 64'd0);
      if (k == 451)  check("y_line1", 64'(a_y), 64'd0);
      if (k == 851)  check("y_line2", 64'(a_y), 64'd1);
      if (k == 6400) check("last_vis_line", 64'({b_wr, b_fs, b_y}), 64'h007);
      if (k == 6401) check("vblank_start", 64'({b_wr, b_fs, b_y}), 64'h3FF);
      if (k == 6402) check("fs_one_clk", 64'({b_wr, b_fs}), 64'h2);
      if (k == 7203) check("vsync_before", 64'(b_vs), 64'd1);
      if (k == 7204) check("vsync_start", 64'(b_vs), 64'd0);
      if (k == 9201) check("next_frame", 64'({b_wr, b_y}), 64'h000);

      // Pulse-width and period measurements
      if (a_hs == 1'b0) begin
        hs_run++;
      end else if (hs_run > 0) begin
        check("hsync_width", 64'(hs_run), 64'd48);
        hs_run = 0;
      end
      if (b_vs == 1'b0) begin
        vs_run++;
      end else if (vs_run > 0) begin
        check("vsync_width", 64'(vs_run), 64'(VS_B * HT));
        vs_run = 0;
      end
      if (k == 0) begin
        last_fs = -1;
      end else if (b_fs) begin
        if (last_fs < 0) check("fs_after_release", 64'(k), 64'(VV_B * HT + 1));
        else             check("frame_period", 64'(k - last_fs), 64'((VV_B + VF_B + VS_B + VB_B) * HT));
        last_fs = k;
      end
    end
  end

  task automatic run_to(input int target);
    int n = 0;
    while (k != target && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      total_cnt++;
      $display("FAIL run_to timeout k=%0d expected=%0d", k, target);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
`ifdef GPU_VBLANK_IRQ_EN
    run_to(6410);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
`endif
    // Reset in the middle of a line, then let the raster restart
    run_to(12150);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    phase = 2;
`ifdef GPU_VBLANK_IRQ_EN
    run_to(6399);
    irq_ack = 1'b1;
    run_to(6403);
    irq_ack = 1'b0;
`endif
    run_to(15700);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
